four_phase_arbiter: RTL and testbench
=====================================

FOUR_PHASE_ARBITER -- requirements
Module: four_phase_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of requesters, range 2..16.
REQ-002 Parameter DW, default 32: bundled-data width.
REQ-003 Parameter TIMEOUT, default 255: cycle limit per wait state; 0 disables the timeout.
REQ-004 Parameter SYNC_STAGES, default 2: hs_ack_i synchronizer depth, minimum 2.
REQ-005 Port clk_i, input, 1: the single clock; all state updates on its rising edge.
REQ-006 Port rst_ni, input, 1: reset, asynchronous, active-low.
REQ-007 Port req_valid_i, input, NREQ: per-requester transfer request, level.
REQ-008 Port req_data_i, input, NREQ*DW: per-requester data; slice i is bits [i*DW +: DW].
REQ-009 Port req_done_o, output, NREQ: one-cycle pulse on the granted bit when its transfer completes.
REQ-010 Port req_err_o, output, NREQ: one-cycle pulse on the granted bit when its transfer times out.
REQ-011 Port hs_req_o, output, 1: four-phase request to the C-element pipeline stage; registered.
REQ-012 Port hs_data_o, output, DW: bundled data; registered; stable whenever hs_req_o is high.
REQ-013 Port hs_ack_i, input, 1: four-phase acknowledge from the stage; asynchronous to clk_i.
REQ-014 Port grant_idx_o, output, $clog2(NREQ): index of the current or last granted requester.
REQ-015 Port busy_o, output, 1: high whenever the state is not IDLE.

Function
REQ-016 hs_ack_i shall pass through SYNC_STAGES flops (all reset to 0); the FSM shall use only the last stage, ack_s.
REQ-017 FSM states: IDLE, SETUP, WAIT_HI, WAIT_LO, DONE, ERR, DRAIN.
REQ-018 IDLE -> SETUP when any req_valid_i bit is 1 and ack_s = 0; otherwise stay in IDLE.
REQ-019 Grant selection shall be round-robin:
- Pick the first valid index at or after pointer ptr, wrapping modulo NREQ.
- ptr resets to 0.
- ptr becomes granted+1 mod NREQ on the IDLE->SETUP edge.
REQ-020 On the IDLE->SETUP edge:
- hs_data_o shall load req_data_i slice of the granted index.
- grant_idx_o shall load that index.
- req_data_i and req_valid_i are ignored for the rest of the transfer.
REQ-021 SETUP shall last exactly one cycle with hs_req_o = 0 (bundling setup), then go to WAIT_HI.
REQ-022 hs_req_o shall be 1 only in WAIT_HI.
REQ-023 WAIT_HI -> WAIT_LO when ack_s = 1.
REQ-024 WAIT_LO -> DONE when ack_s = 0.
REQ-025 DONE shall last one cycle, with req_done_o[grant_idx_o] = 1, then go to IDLE.
REQ-026 A cycle counter shall clear on entry to WAIT_HI and on entry to WAIT_LO, and increment every cycle in those states.
- Counter width: $clog2(TIMEOUT+1).
- The counter shall saturate and never wrap.
REQ-027 If TIMEOUT > 0 and the counter reaches TIMEOUT while in WAIT_HI or WAIT_LO, the next state shall be ERR; the ack_s transition shall take priority if both occur in the same cycle.
REQ-028 ERR shall last one cycle, with req_err_o[grant_idx_o] = 1 and hs_req_o = 0, then go to DRAIN.
REQ-029 DRAIN -> IDLE when ack_s = 0; no timeout applies in DRAIN.
REQ-030 A requester dropping req_valid_i after its grant shall not abort the transfer; its done or err pulse still occurs.
REQ-031 Minimum spacing between grant edges shall be 9 cycles (SYNC_STAGES = 2, zero-delay ack).
REQ-032 req_done_o and req_err_o shall never be nonzero in the same cycle, and at most one bit of each shall be set.

Reset
REQ-033 While rst_ni = 0, the block shall immediately hold these values:
- state IDLE, ptr 0, counter 0, synchronizer flops 0.
- hs_req_o 0, hs_data_o 0, grant_idx_o 0.
- req_done_o 0, req_err_o 0, busy_o 0.
REQ-034 Reset asserted mid-transfer shall drop hs_req_o without waiting for ack; after release, REQ-018 blocks any grant until ack_s = 0.

Verification
REQ-035 Single transfer: NREQ = 4, req_valid_i = 4'b0100, data 0xA5A5_0002, hs_ack_i = hs_req_o delayed 1 ns. Required response:
- SETUP on the sampling edge E0.
- hs_req_o high after E1.
- hs_data_o = 0xA5A5_0002.
- req_done_o = 4'b0100 for one cycle after E7.
- busy_o low after E8.
REQ-036 Round-robin: req_valid_i = 4'b1111 held for 4 transfers -> grant_idx_o sequence 0,1,2,3, then 0 again on the fifth transfer.
REQ-037 Timeout: TIMEOUT = 10, hs_ack_i held 0 -> req_err_o pulses on the granted bit, hs_req_o falls 0 within one cycle of the pulse, and the FSM returns to IDLE via DRAIN.
REQ-038 Stuck ack: TIMEOUT = 10, hs_ack_i held 1 after rising -> WAIT_LO times out, err pulses, and the FSM stays in DRAIN until hs_ack_i is driven 0, then returns to IDLE.
REQ-039 Reset mid-transfer: rst_ni driven 0 while in WAIT_HI with hs_ack_i = 1 -> hs_req_o is 0 immediately; after release, no grant occurs until hs_ack_i = 0 has propagated through the synchronizer.
REQ-040 Valid withdrawn: req_valid_i bit dropped one cycle after its grant -> the transfer completes and req_done_o still pulses on that bit.

Source files
------------

// File: rtl/four_phase_arbiter.sv
// Round-robin arbiter that funnels NREQ bundled-data requesters into a single
// four-phase (return-to-zero) handshake towards an asynchronous pipeline stage.
module four_phase_arbiter #(
  parameter int NREQ        = 4,
  parameter int DW          = 32,
  parameter int TIMEOUT     = 255,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [NREQ-1:0]          req_valid_i,
  input  logic [NREQ*DW-1:0]       req_data_i,
  output logic [NREQ-1:0]          req_done_o,
  output logic [NREQ-1:0]          req_err_o,
  output logic                     hs_req_o,
  output logic [DW-1:0]            hs_data_o,
  input  logic                     hs_ack_i,
  output logic [$clog2(NREQ)-1:0]  grant_idx_o,
  output logic                     busy_o
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);

  typedef enum logic [2:0] {
    IDLE, SETUP, WAIT_HI, WAIT_LO, DONE, ERR, DRAIN
  } state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] ackSync_q;
  logic                   ackS;
  logic [IW-1:0]          ptr_q;
  logic [IW-1:0]          grantIdx_q;
  logic [DW-1:0]          hsData_q;
  logic                   hsReq_q;
  logic [CW-1:0]          cnt_q;
  logic [IW-1:0]          pick;
  logic [IW-1:0]          cand;
  logic [IW-1:0]          ptrNext;
  logic                   timeoutHit;
  logic                   grantEdge;
  logic                   enterWait;
  logic [NREQ-1:0]        grantOneHot;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ackSync_q <= '0;
    end else begin
      ackSync_q <= {ackSync_q[SYNC_STAGES-2:0], hs_ack_i};
    end
  end

  assign ackS = ackSync_q[SYNC_STAGES-1];

  // Scanning downwards lets the candidate closest to ptr overwrite all others.
  always_comb begin
    pick = ptr_q;
    cand = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = IW'((int'(ptr_q) + k) % NREQ);
      if (req_valid_i[cand]) begin
        pick = cand;
      end
    end
  end

  assign ptrNext    = (pick == IW'(NREQ - 1)) ? '0 : pick + 1'b1;
  assign timeoutHit = (TIMEOUT > 0) && (cnt_q == CNT_MAX);
  assign grantEdge  = (state_q == IDLE) && (state_d == SETUP);
  assign enterWait  = (state_d != state_q) && ((state_d == WAIT_HI) || (state_d == WAIT_LO));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // An ack edge always wins over a timeout seen in the same cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if ((|req_valid_i) && !ackS) state_d = SETUP;
      SETUP:   state_d = WAIT_HI;
      WAIT_HI: begin
        if (ackS)            state_d = WAIT_LO;
        else if (timeoutHit) state_d = ERR;
      end
      WAIT_LO: begin
        if (!ackS)           state_d = DONE;
        else if (timeoutHit) state_d = ERR;
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = DRAIN;
      DRAIN:   if (!ackS) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q      <= '0;
      grantIdx_q <= '0;
      hsData_q   <= '0;
      hsReq_q    <= 1'b0;
      cnt_q      <= '0;
    end else begin
      hsReq_q <= (state_d == WAIT_HI);
      if (grantEdge) begin
        ptr_q      <= ptrNext;
        grantIdx_q <= pick;
        hsData_q   <= req_data_i[pick*DW +: DW];
      end
      if (enterWait) begin
        cnt_q <= '0;
      end else if (((state_q == WAIT_HI) || (state_q == WAIT_LO)) && (cnt_q != '1)) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign grantOneHot = {{(NREQ-1){1'b0}}, 1'b1} << grantIdx_q;

  always_comb begin
    req_done_o = '0;
    req_err_o  = '0;
    busy_o     = (state_q != IDLE);
    if (state_q == DONE) req_done_o = grantOneHot;
    if (state_q == ERR)  req_err_o  = grantOneHot;
  end

  assign hs_req_o    = hsReq_q;
  assign hs_data_o   = hsData_q;
  assign grant_idx_o = grantIdx_q;

endmodule

// File: tb/tb_four_phase_arbiter.sv
// Randomized scoreboard bench for four_phase_arbiter with a behavioural
// round-robin model and a programmable four-phase ack responder.
module tb_four_phase_arbiter;

  localparam int NREQ    = 4;
  localparam int DW      = 32;
  localparam int TMO     = 10;
  localparam int FOLLOW  = 0;
  localparam int HOLD0   = 1;
  localparam int HOLD1   = 2;
  localparam int STUCK1  = 3;

  logic              clk = 1'b0;
  logic              rst_ni = 1'b1;
  logic [NREQ-1:0]   req_valid_i = '0;
  logic [NREQ*DW-1:0] req_data_i = '0;
  logic [NREQ-1:0]   req_done_o;
  logic [NREQ-1:0]   req_err_o;
  logic              hs_req_o;
  logic [DW-1:0]     hs_data_o;
  logic              hs_ack_i = 1'b0;
  logic [1:0]        grant_idx_o;
  logic              busy_o;

  typedef struct {
    int          idx;
    logic [31:0] data;
    bit          isErr;
  } exp_t;

  exp_t sbQ[$];
  int   errors = 0;
  int   checks = 0;
  int   modelPtr = 0;
  int   ackMode = FOLLOW;
  logic lastReq = 1'b0;
  bit   stuck = 1'b0;

  four_phase_arbiter #(
    .NREQ(NREQ), .DW(DW), .TIMEOUT(TMO), .SYNC_STAGES(2)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni), .req_valid_i(req_valid_i), .req_data_i(req_data_i),
    .req_done_o(req_done_o), .req_err_o(req_err_o), .hs_req_o(hs_req_o),
    .hs_data_o(hs_data_o), .hs_ack_i(hs_ack_i), .grant_idx_o(grant_idx_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  // Pipeline-stage stand-in: ack mirrors req about 1 ns late unless a fault mode is chosen.
  always begin
    case (ackMode)
      FOLLOW:  hs_ack_i = lastReq;
      HOLD0:   hs_ack_i = 1'b0;
      HOLD1:   hs_ack_i = 1'b1;
      default: begin
        if (lastReq) stuck = 1'b1;
        hs_ack_i = stuck;
      end
    endcase
    if (ackMode != STUCK1) stuck = 1'b0;
    lastReq = hs_req_o;
    #1;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, want %0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic int rrPick(input logic [3:0] m, input int p);
    for (int k = 0; k < NREQ; k++) begin
      if (m[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  // Monitor: every done/err pulse consumes one scoreboard entry.
  always @(negedge clk) begin
    exp_t e;
    logic [3:0] oh;
    if (rst_ni && ((req_done_o != '0) || (req_err_o != '0))) begin
      checkOutput("done_err_exclusive", {31'b0, (|req_done_o) && (|req_err_o)}, 32'd0);
      if (sbQ.size() == 0) begin
        checkOutput("unexpected_pulse", {req_err_o, req_done_o}, 32'd0);
      end else begin
        e  = sbQ.pop_front();
        oh = 4'b0001 << e.idx;
        checkOutput("done_vec", req_done_o, e.isErr ? 32'd0 : 32'(oh));
        checkOutput("err_vec", req_err_o, e.isErr ? 32'(oh) : 32'd0);
        checkOutput("grant_idx_at_end", grant_idx_o, e.idx);
        checkOutput("hs_data", hs_data_o, e.data);
        checkOutput("hs_req_low_at_end", hs_req_o, 32'd0);
      end
    end
  end

  task automatic doReset();
    rst_ni = 1'b0;
    #1;
    checkOutput("rst_hs_req", hs_req_o, 0);
    checkOutput("rst_hs_data", hs_data_o, 0);
    checkOutput("rst_grant", grant_idx_o, 0);
    checkOutput("rst_done_err", {req_err_o, req_done_o}, 0);
    checkOutput("rst_busy", busy_o, 0);
    repeat (2) @(posedge clk);
    #1 rst_ni = 1'b1;
    modelPtr = 0;
    sbQ.delete();
  endtask

  // One complete transfer with cycle-accurate latency expectations per ack mode.
  task automatic applyStimulus(input logic [3:0] mask, input int dropMode, input int mode, input bit directed);
    logic [31:0] data [NREQ];
    exp_t e;
    int g, reqRise, doneCyc, errCyc, busyFall, k;
    ackMode = mode;
    for (int i = 0; i < NREQ; i++) begin
      data[i] = directed ? (32'hA5A5_0000 | i) : $urandom;
      req_data_i[i*DW +: DW] = data[i];
    end
    g = rrPick(mask, modelPtr);
    modelPtr = (g + 1) % NREQ;
    e.idx = g; e.data = data[g]; e.isErr = (mode != FOLLOW);
    sbQ.push_back(e);
    req_valid_i = mask;
    @(posedge clk); #1;
    checkOutput("busy_at_grant", busy_o, 1);
    checkOutput("grant_idx", grant_idx_o, g);
    if (dropMode == 1) req_valid_i = mask & ~(4'b0001 << g);
    else if (dropMode == 2) req_valid_i = 4'($urandom);
    req_data_i = {$urandom, $urandom, $urandom, $urandom};
    reqRise = -1; doneCyc = -1; errCyc = -1; busyFall = -1;
    for (k = 1; k <= 60; k++) begin
      @(posedge clk); #1;
      if (hs_req_o && reqRise < 0) reqRise = k;
      if (req_done_o != '0) doneCyc = k;
      if (req_err_o != '0) errCyc = k;
      if (!busy_o) begin busyFall = k; break; end
      if (mode == STUCK1 && errCyc >= 0 && k == errCyc + 5) break;
    end
    checkOutput("req_rise_cycle", reqRise, 1);
    if (mode == FOLLOW) begin
      checkOutput("done_cycle", doneCyc, 7);
      checkOutput("idle_cycle", busyFall, 8);
    end else if (mode == HOLD0) begin
      checkOutput("err_cycle_hi", errCyc, TMO + 2);
      checkOutput("idle_cycle_tmo", busyFall, TMO + 4);
    end else begin
      checkOutput("err_cycle_lo", errCyc, TMO + 5);
      checkOutput("drain_busy", busy_o, 1);
      checkOutput("drain_req_low", hs_req_o, 0);
      ackMode = FOLLOW;
      busyFall = -1;
      for (k = 1; k <= 10; k++) begin
        @(posedge clk); #1;
        if (!busy_o) begin busyFall = k; break; end
      end
      checkOutput("drain_exit_cycle", busyFall, 3);
    end
    req_valid_i = '0;
    ackMode = FOLLOW;
  endtask

  task automatic resetMidTransfer();
    exp_t e;
    int k, grantAt;
    bit sawBusy;
    ackMode = FOLLOW;
    req_data_i[0 +: DW] = $urandom;
    req_valid_i = 4'b0001;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("rmt_req_high", hs_req_o, 1);
    ackMode = HOLD1;
    #2;
    rst_ni = 1'b0;
    #1;
    checkOutput("rmt_req_dropped", hs_req_o, 0);
    checkOutput("rmt_busy_dropped", busy_o, 0);
    req_valid_i = '0;
    repeat (2) @(posedge clk);
    #1 rst_ni = 1'b1;
    modelPtr = 0;
    sbQ.delete();
    repeat (3) @(posedge clk);
    #1 req_valid_i = 4'b0001;
    sawBusy = 1'b0;
    for (k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (busy_o) sawBusy = 1'b1;
    end
    checkOutput("rmt_no_grant_ack_high", sawBusy, 0);
    e.idx = 0; e.data = req_data_i[0 +: DW]; e.isErr = 1'b0;
    sbQ.push_back(e);
    modelPtr = 1;
    ackMode = FOLLOW;
    grantAt = -1;
    for (k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      if (busy_o) begin grantAt = k; break; end
    end
    checkOutput("rmt_grant_after_sync", grantAt, 3);
    req_valid_i = '0;
    for (k = 0; k < 20 && busy_o; k++) begin
      @(posedge clk); #1;
    end
    checkOutput("rmt_idle", busy_o, 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [3:0] m;
    #1;
    doReset();
    applyStimulus(4'b0100, 0, FOLLOW, 1'b1);
    applyStimulus(4'b0010, 1, FOLLOW, 1'b0);
    applyStimulus(4'b1001, 0, HOLD0, 1'b0);
    applyStimulus(4'b0110, 0, STUCK1, 1'b0);
    resetMidTransfer();
    doReset();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(4'b1111, 0, FOLLOW, 1'b0);
      checkOutput("rr_sequence", grant_idx_o, i % NREQ);
    end
    for (int i = 0; i < 40; i++) begin
      m = 4'($urandom_range(1, 15));
      applyStimulus(m, $urandom_range(0, 2), ($urandom_range(0, 5) == 0) ? HOLD0 : FOLLOW, 1'b0);
    end
    repeat (3) @(posedge clk);
    #1 checkOutput("scoreboard_drained", sbQ.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
